// File: rtl/instruction_fetch_unit_if.sv
// Decoder-side instruction handshake.
// master: the fetch unit; drives opcode/operand/instr_valid, samples instr_ready.
// slave : the decoder; samples the instruction, drives instr_ready.
//   opcode      - latched opcode word
//   operand     - latched operand word (0 for one-word instructions)
//   instr_valid - opcode/operand hold a complete instruction
//   instr_ready - decoder accepts the instruction this cycle
interface instruction_fetch_unit_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] opcode;
    logic [DATA_WIDTH-1:0] operand;
    logic                  instr_valid;
    logic                  instr_ready;

    modport master (
        output opcode,
        output operand,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  opcode,
        input  operand,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the program counter and walks each instruction
// through FETCH -> DECODE -> OPERAND -> ISSUE. It reads the opcode word at PC
// and always peeks at PC+1, then keeps that second word only when the opcode MSB
// marks a two-word instruction. Jumps from execute redirect the PC from any
// state. Halt only holds the unit in FETCH.
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   p_ram_rdata             - program RAM read data (one cycle after the address)
//   program_counter_address - current PC, to the memory controller
//   fetch_control           - controller microcode: 0 = read at PC, 5 = PEEK at PC+1
//   decoder                 - opcode/operand/valid/ready handshake to the decoder
//   jump_valid/jump_address - redirect request and its target
//   halt                    - blocks the start of a new fetch
module instruction_fetch_unit #(
    parameter int                     ADDRESS_WIDTH = 16,
    parameter int                     DATA_WIDTH    = 16,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_WIDTH-1:0]    p_ram_rdata,
    output logic [ADDRESS_WIDTH-1:0] program_counter_address,
    output logic [2:0]               fetch_control,
    instruction_fetch_unit_if.master decoder,
    input  logic                     jump_valid,
    input  logic [ADDRESS_WIDTH-1:0] jump_address,
    input  logic                     halt
);

    localparam logic [1:0] FETCH   = 2'd0;
    localparam logic [1:0] DECODE  = 2'd1;
    localparam logic [1:0] OPERAND = 2'd2;
    localparam logic [1:0] ISSUE   = 2'd3;

    localparam logic [2:0] CTRL_DEFAULT = 3'd0;
    localparam logic [2:0] CTRL_PEEK    = 3'd5;

    logic [1:0]               state;
    logic [ADDRESS_WIDTH-1:0] pc;
    logic                     two_word;
    logic [DATA_WIDTH-1:0]    opcode_q;
    logic [DATA_WIDTH-1:0]    operand_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            pc        <= RESET_VECTOR;
            two_word  <= 1'b0;
            opcode_q  <= '0;
            operand_q <= '0;
        end else if (jump_valid) begin
            // A redirect wins over everything, including an accept in ISSUE;
            // whatever was in flight is simply abandoned.
            pc    <= jump_address;
            state <= FETCH;
        end else begin
            case (state)
                FETCH: begin
                    if (!halt) begin
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    opcode_q <= p_ram_rdata;
                    two_word <= p_ram_rdata[DATA_WIDTH-1];
                    state    <= OPERAND;
                end
                OPERAND: begin
                    // The PEEK read always happens; only two-word opcodes keep it.
                    operand_q <= two_word ? p_ram_rdata : '0;
                    state     <= ISSUE;
                end
                ISSUE: begin
                    if (decoder.instr_ready) begin
                        pc    <= pc + (two_word ? ADDRESS_WIDTH'(2) : ADDRESS_WIDTH'(1));
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    // Moore outputs: decoded from state only.
    always_comb begin
        fetch_control = CTRL_DEFAULT;
        if (state == DECODE) begin
            fetch_control = CTRL_PEEK;
        end
    end

    assign program_counter_address = pc;
    assign decoder.opcode          = opcode_q;
    assign decoder.operand         = operand_q;
    assign decoder.instr_valid     = (state == ISSUE);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] p_ram_rdata;
    logic [15:0] program_counter_address;
    logic [2:0]  fetch_control;
    logic        jump_valid;
    logic [15:0] jump_address;
    logic        halt;

    instruction_fetch_unit_if #(.DATA_WIDTH(16)) dec_if ();

    instruction_fetch_unit #(
        .ADDRESS_WIDTH(16),
        .DATA_WIDTH   (16),
        .RESET_VECTOR (16'h0000)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .p_ram_rdata            (p_ram_rdata),
        .program_counter_address(program_counter_address),
        .fetch_control          (fetch_control),
        .decoder                (dec_if.master),
        .jump_valid             (jump_valid),
        .jump_address           (jump_address),
        .halt                   (halt)
    );

    // Program RAM behind a memory-controller model: PEEK reads PC+1 (wrapping).
    logic [15:0] mem [0:65535];
    always @(posedge clk) begin
        if (fetch_control == 3'd5)
            p_ram_rdata <= mem[16'(program_counter_address + 16'd1)];
        else
            p_ram_rdata <= mem[program_counter_address];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;
    logic [15:0] model_pc;   // architectural PC the reference expects

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from FETCH to its accept, checking every cycle
    // against the architectural meaning of the words at model_pc.
    task automatic issue_one(input string name, input int stall);
        logic [15:0] exp_op, exp_operand, exp_next;
        exp_op      = mem[model_pc];
        exp_operand = exp_op[15] ? mem[16'(model_pc + 16'd1)] : 16'h0000;
        exp_next    = 16'(model_pc + (exp_op[15] ? 16'd2 : 16'd1));
        dec_if.instr_ready = (stall == 0);

        total_cnt++;
        if (fetch_control !== 3'd0 || dec_if.instr_valid !== 1'b0 || program_counter_address !== model_pc)
            $display("FAIL %s fetch_cycle: fc=%0d valid=%0b pc=%h want fc=0 valid=0 pc=%h", name, fetch_control, dec_if.instr_valid, program_counter_address, model_pc);
        else pass_cnt++;
        step();
        total_cnt++;
        if (fetch_control !== 3'd5 || dec_if.instr_valid !== 1'b0)
            $display("FAIL %s decode_cycle: fc=%0d valid=%0b want fc=5 valid=0", name, fetch_control, dec_if.instr_valid);
        else pass_cnt++;
        step();
        total_cnt++;
        if (fetch_control !== 3'd0 || dec_if.instr_valid !== 1'b0 || dec_if.opcode !== exp_op)
            $display("FAIL %s operand_cycle: fc=%0d valid=%0b opcode=%h want fc=0 valid=0 opcode=%h", name, fetch_control, dec_if.instr_valid, dec_if.opcode, exp_op);
        else pass_cnt++;
        step();
        total_cnt++;
        if (dec_if.instr_valid !== 1'b1 || dec_if.opcode !== exp_op || dec_if.operand !== exp_operand || fetch_control !== 3'd0)
            $display("FAIL %s issue: valid=%0b op=%h opnd=%h fc=%0d want valid=1 op=%h opnd=%h fc=0", name, dec_if.instr_valid, dec_if.opcode, dec_if.operand, fetch_control, exp_op, exp_operand);
        else pass_cnt++;
        for (int i = 0; i < stall; i++) begin
            step();
            total_cnt++;
            if (dec_if.instr_valid !== 1'b1 || dec_if.opcode !== exp_op || dec_if.operand !== exp_operand || program_counter_address !== model_pc)
                $display("FAIL %s stall_hold: valid=%0b op=%h opnd=%h pc=%h want 1 %h %h %h", name, dec_if.instr_valid, dec_if.opcode, dec_if.operand, program_counter_address, exp_op, exp_operand, model_pc);
            else pass_cnt++;
        end
        dec_if.instr_ready = 1'b1;
        step();
        dec_if.instr_ready = 1'b0;
        total_cnt++;
        if (dec_if.instr_valid !== 1'b0 || program_counter_address !== exp_next)
            $display("FAIL %s accept: valid=%0b pc=%h want valid=0 pc=%h", name, dec_if.instr_valid, program_counter_address, exp_next);
        else pass_cnt++;
        model_pc = exp_next;
    endtask

    // Jump issued while the unit sits in FETCH.
    task automatic jump_to(input logic [15:0] target);
        jump_valid   = 1'b1;
        jump_address = target;
        step();
        jump_valid = 1'b0;
        model_pc   = target;
        total_cnt++;
        if (program_counter_address !== target || dec_if.instr_valid !== 1'b0)
            $display("FAIL jump_to: pc=%h valid=%0b want pc=%h valid=0", program_counter_address, dec_if.instr_valid, target);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        total_cnt++;
        if (program_counter_address !== 16'h0000 || fetch_control !== 3'd0 || dec_if.opcode !== 16'h0000 || dec_if.operand !== 16'h0000 || dec_if.instr_valid !== 1'b0)
            $display("FAIL reset_values: pc=%h fc=%0d op=%h opnd=%h valid=%0b want all 0", program_counter_address, fetch_control, dec_if.opcode, dec_if.operand, dec_if.instr_valid);
        else pass_cnt++;
        rst_n    = 1'b1;
        model_pc = 16'h0000;
    endtask

    task automatic test_one_word();
        mem[16'h0000] = 16'h0012;
        issue_one("one_word", 0);
    endtask

    task automatic test_two_word();
        mem[16'h0004] = 16'h8003;
        mem[16'h0005] = 16'hBEEF;
        jump_to(16'h0004);
        issue_one("two_word", 0);
    endtask

    task automatic test_stall();
        mem[16'h0006] = 16'h0042;
        issue_one("stall", 5);
    endtask

    task automatic test_jump_vs_ready();
        mem[16'h0007] = 16'h0011;
        mem[16'h0100] = 16'h8077;
        mem[16'h0101] = 16'h1111;
        step(); step(); step();
        total_cnt++;
        if (dec_if.instr_valid !== 1'b1)
            $display("FAIL jump_ready_reach_issue: valid=%0b want 1", dec_if.instr_valid);
        else pass_cnt++;
        dec_if.instr_ready = 1'b1;
        jump_valid   = 1'b1;
        jump_address = 16'h0100;
        step();
        dec_if.instr_ready = 1'b0;
        jump_valid = 1'b0;
        total_cnt++;
        if (program_counter_address !== 16'h0100 || dec_if.instr_valid !== 1'b0)
            $display("FAIL jump_over_ready: pc=%h valid=%0b want pc=0100 valid=0", program_counter_address, dec_if.instr_valid);
        else pass_cnt++;
        model_pc = 16'h0100;
        issue_one("after_jump", 0);
    endtask

    task automatic test_jump_in_decode();
        mem[model_pc]  = 16'h0999;
        mem[16'h0200]  = 16'h0005;
        step();
        jump_valid   = 1'b1;
        jump_address = 16'h0200;
        step();
        jump_valid = 1'b0;
        total_cnt++;
        if (program_counter_address !== 16'h0200 || dec_if.instr_valid !== 1'b0 || fetch_control !== 3'd0)
            $display("FAIL jump_in_decode: pc=%h valid=%0b fc=%0d want 0200 0 0", program_counter_address, dec_if.instr_valid, fetch_control);
        else pass_cnt++;
        model_pc = 16'h0200;
        issue_one("discarded_fetch", 0);
    endtask

    task automatic test_wrap();
        mem[16'hFFFF] = 16'h8001;
        mem[16'h0000] = 16'h1234;
        jump_to(16'hFFFF);
        issue_one("wrap", 1);
        total_cnt++;
        if (model_pc !== 16'h0001 || program_counter_address !== 16'h0001)
            $display("FAIL wrap_pc: pc=%h want 0001", program_counter_address);
        else pass_cnt++;
    endtask

    task automatic test_halt();
        logic [15:0] held_pc;
        halt    = 1'b1;
        held_pc = program_counter_address;
        for (int i = 0; i < 8; i++) begin
            step();
            total_cnt++;
            if (fetch_control !== 3'd0 || dec_if.instr_valid !== 1'b0 || program_counter_address !== held_pc)
                $display("FAIL halt_hold: fc=%0d valid=%0b pc=%h want 0 0 %h", fetch_control, dec_if.instr_valid, program_counter_address, held_pc);
            else pass_cnt++;
        end
        mem[16'h0300] = 16'h0033;
        jump_to(16'h0300);
        step(); step();
        total_cnt++;
        if (fetch_control !== 3'd0 || dec_if.instr_valid !== 1'b0 || program_counter_address !== 16'h0300)
            $display("FAIL halt_after_jump: fc=%0d valid=%0b pc=%h want 0 0 0300", fetch_control, dec_if.instr_valid, program_counter_address);
        else pass_cnt++;
        halt = 1'b0;
        mem[16'h0301] = 16'h0044;
        // Halt raised after FETCH must not stop the instruction already in flight.
        step();
        halt = 1'b1;
        step(); step();
        total_cnt++;
        if (dec_if.instr_valid !== 1'b1 || dec_if.opcode !== 16'h0033)
            $display("FAIL halt_inflight: valid=%0b op=%h want 1 0033", dec_if.instr_valid, dec_if.opcode);
        else pass_cnt++;
        dec_if.instr_ready = 1'b1;
        step();
        dec_if.instr_ready = 1'b0;
        step(); step();
        total_cnt++;
        if (program_counter_address !== 16'h0301 || fetch_control !== 3'd0 || dec_if.instr_valid !== 1'b0)
            $display("FAIL halt_after_accept: pc=%h fc=%0d valid=%0b want 0301 0 0", program_counter_address, fetch_control, dec_if.instr_valid);
        else pass_cnt++;
        halt     = 1'b0;
        model_pc = 16'h0301;
    endtask

    task automatic test_async_reset();
        mem[model_pc] = 16'h8555;
        step(); step();
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (program_counter_address !== 16'h0000 || fetch_control !== 3'd0 || dec_if.opcode !== 16'h0000 || dec_if.operand !== 16'h0000 || dec_if.instr_valid !== 1'b0)
            $display("FAIL async_reset: pc=%h fc=%0d op=%h opnd=%h valid=%0b want all 0", program_counter_address, fetch_control, dec_if.opcode, dec_if.operand, dec_if.instr_valid);
        else pass_cnt++;
        step();
        rst_n    = 1'b1;
        model_pc = 16'h0000;
        mem[16'h0000] = 16'h0021;
        issue_one("post_reset", 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            logic [15:0] target;
            target = 16'($urandom);
            mem[target]                = 16'($urandom);
            mem[16'(target + 16'd1)]   = 16'($urandom);
            jump_to(target);
            issue_one("random", int'($urandom_range(0, 3)));
            mem[model_pc] = 16'($urandom);
            if (model_pc != target)
                mem[16'(model_pc + 16'd1)] = 16'($urandom);
            issue_one("random_seq", int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        for (int unsigned a = 0; a < 65536; a++) mem[a] = 16'h0000;
        rst_n              = 1'b0;
        jump_valid         = 1'b0;
        jump_address       = 16'h0000;
        halt               = 1'b0;
        dec_if.instr_ready = 1'b0;
        model_pc           = 16'h0000;
        #3;
        test_reset();
        test_one_word();
        test_two_word();
        test_stall();
        test_jump_vs_ready();
        test_jump_in_decode();
        test_wrap();
        test_halt();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Owns the program counter and sequences instruction fetches from program RAM through the memory controller. It drives the controller's PC address and 3-bit microcode control, captures the opcode word and an optional operand word from the RAM read bus, and hands complete instructions to the decoder over a valid/ready handshake. It also accepts redirects (jumps) from the execute stage and a halt request.

## Interface
Parameters:
- ADDRESS_WIDTH, 16, program counter / program RAM address width
- DATA_WIDTH, 16, program RAM word width; MSB of the opcode word flags a two-word instruction
- RESET_VECTOR, 0, PC value after reset

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- p_ram_rdata  input  DATA_WIDTH  program RAM read data; synchronous RAM, valid the cycle after the address is presented
- program_counter_address  output  ADDRESS_WIDTH  current PC, to memory controller
- fetch_control  output  3  microcode control to memory controller: 0 = default (read at PC), 5 = PEEK (read at PC+1)
- opcode  output  DATA_WIDTH  latched opcode word
- operand  output  DATA_WIDTH  latched operand word; 0 for one-word instructions
- instr_valid  output  1  opcode/operand hold a complete instruction
- instr_ready  input  1  decoder accepts the instruction this cycle
- jump_valid  input  1  redirect request
- jump_address  input  ADDRESS_WIDTH  redirect target
- halt  input  1  hold fetch; no new fetch starts while high

Clock and reset: one clock; reset is asynchronous and active-low.

## Operation
- States: FETCH, DECODE, OPERAND, ISSUE. Reset state FETCH.
- FETCH: fetch_control=0, so the controller presents PC to RAM. If halt=1 stay in FETCH; else go to DECODE.
- DECODE: latch opcode <= p_ram_rdata; record two_word <= p_ram_rdata[DATA_WIDTH-1]. fetch_control=5 (PEEK) unconditionally. Go to OPERAND.
- OPERAND: fetch_control=0; operand <= two_word ? p_ram_rdata : 0. Go to ISSUE.
- ISSUE: instr_valid=1, fetch_control=0. opcode/operand stable while valid. On instr_ready=1: PC <= PC + (two_word ? 2 : 1), go to FETCH. Otherwise hold.
- Jump: jump_valid=1 in any state: PC <= jump_address, state <= FETCH, instr_valid drops next cycle; any in-flight opcode/operand discarded. Jump has priority over instr_ready in the same cycle (PC takes jump_address, not the increment). Halt does not block a jump; after a jump with halt=1 the unit waits in FETCH.
- halt only gates FETCH->DECODE; an instruction already past FETCH completes and issues.
- Arithmetic: PC increments are modulo 2^ADDRESS_WIDTH (0xFFFF+1 = 0x0000, 0xFFFF+2 = 0x0001). PEEK at PC=0xFFFF reads address 0x0000 (controller wraps).
- opcode/operand retain their last value outside ISSUE; only instr_valid qualifies them.

## Timing
- Reset values: program_counter_address=RESET_VECTOR, fetch_control=0, opcode=0, operand=0, instr_valid=0, state FETCH, two_word=0.
- fetch_control and instr_valid are decoded from state (Moore), no combinational path from inputs.
- Latency: instr_valid rises 3 cycles after entering FETCH (FETCH, DECODE, OPERAND, then ISSUE).
- Throughput with instr_ready tied high and no halt: one instruction per 4 cycles, one- and two-word alike.
- instr_valid falls the cycle after the accepting handshake or after a jump.
- Reset asserted mid-instruction: all state returns to reset values immediately, regardless of clock.

## Test plan
- Reset release, RAM[0]=0x0012, ready=1 -> fetch_control 0,5,0 in cycles 0-2; cycle 3 instr_valid=1, opcode=0x0012, operand=0; PC becomes 1 next cycle.
- RAM[4]=0x8003, RAM[5]=0xBEEF, PC=4 -> opcode=0x8003, operand=0xBEEF, PC advances to 6 after handshake.
- ISSUE with instr_ready=0 for 5 cycles -> instr_valid held, opcode/operand and PC unchanged; ready=1 -> single accept, PC increments once.
- jump_valid=1, jump_address=0x0100 in the same cycle as instr_ready=1 in ISSUE -> PC=0x0100 (not PC+1), next instruction fetched from 0x0100; jump during DECODE -> no instr_valid for the discarded fetch.
- Two-word instruction at PC=0xFFFF with RAM[0]=0x1234 -> PEEK issued, operand=0x1234, PC wraps to 0x0001; halt=1 held in FETCH -> state never leaves FETCH, instr_valid stays 0; rst_n pulsed low in OPERAND -> outputs return to reset values asynchronously.
